// File: rtl/hcs_pkg.sv
// Shared types for the sensor scheduler: FSM encoding and channel numbering.
// Channel order is the polling order on the shared sensor bus.
package hcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EVAL = 2'd2
    } state_e;

    typedef logic [1:0] ch_t;

    localparam int  NUM_CH      = 4;
    localparam ch_t CH_PRESSURE = 2'd0;
    localparam ch_t CH_BLOOD    = 2'd1;
    localparam ch_t CH_FALL     = 2'd2;
    localparam ch_t CH_TEMP     = 2'd3;

endpackage

// File: rtl/hcs_debounce_ctr.sv
// Per-channel debounce: saturating count of consecutive abnormal samples, sticky hit at DEBOUNCE.
// Updates in one cycle; a set and a clear in the same cycle leave hit high.
module hcs_debounce_ctr #(
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic       flag,
    input  logic       clr,
    output logic [3:0] count,
    output logic       hit
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    logic [3:0] count_q, count_d, inc;
    logic       hit_q, hit_d, set;

    always_comb begin
        inc     = (count_q == DEB) ? DEB : count_q + 4'd1;
        set     = upd && flag && (inc == DEB);
        count_d = count_q;
        hit_d   = hit_q;
        // A sample evaluated in the clear cycle still counts toward the next alarm.
        if (upd) begin
            count_d = flag ? inc : 4'd0;
        end else if (clr) begin
            count_d = 4'd0;
        end
        if (set) begin
            hit_d = 1'b1;
        end else if (clr) begin
            hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
        end
    end

    assign count = count_q;
    assign hit   = hit_q;

endmodule

// File: rtl/hcs_sensor_scheduler.sv
// Round-robin poller for 4 sensors on one bus; ack accepted in the first REQ cycle, 1-cycle EVAL per channel.
// REQ holds until ack (or, with HCS_SCHED_TIMEOUT_EN, skips the channel after TIMEOUT cycles and flags fault).
module hcs_sensor_scheduler
    import hcs_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 100,
    parameter int DEBOUNCE      = 3,
    parameter int TIMEOUT       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       sens_req,
    output logic [1:0] sens_sel,
    input  logic       sens_ack,
    input  logic [7:0] sens_data,
    output logic [7:0] cap_data,
    output logic [1:0] cap_sel,
    input  logic       det_flag,
    output logic [3:0] alarm,
    input  logic [3:0] alarm_clr,
    output logic [3:0] fault,
    output logic       busy
);

    localparam int            PW         = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PW-1:0] PER_RELOAD = PW'(SAMPLE_PERIOD - 1);

    state_e        state_q, state_d;
    ch_t           ch_q, ch_d;
    logic [PW-1:0] per_q, per_d;
    logic [7:0]    cap_data_q, cap_data_d;
    ch_t           cap_sel_q, cap_sel_d;
    logic          eval_upd;
    logic [NUM_CH-1:0]      hit;
    logic [NUM_CH-1:0][3:0] count_unused;

`ifdef HCS_SCHED_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0]     tmo_q, tmo_d;
    logic              tmo_fire;
    logic [NUM_CH-1:0] fault_q, fault_d;
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        per_d      = per_q;
        cap_data_d = cap_data_q;
        cap_sel_d  = cap_sel_q;
        eval_upd   = 1'b0;
`ifdef HCS_SCHED_TIMEOUT_EN
        tmo_fire   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // The period counter only runs while enabled; it is reloaded at round start.
                if (enable) begin
                    if (per_q == '0) begin
                        state_d = ST_REQ;
                        ch_d    = CH_PRESSURE;
                        per_d   = PER_RELOAD;
                    end else begin
                        per_d = per_q - PW'(1);
                    end
                end
            end
            ST_REQ: begin
                if (sens_ack) begin
                    cap_data_d = sens_data;
                    cap_sel_d  = ch_q;
                    state_d    = ST_EVAL;
                end
`ifdef HCS_SCHED_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    ch_d     = ch_q + 2'd1;
                    state_d  = (ch_q == CH_TEMP) ? ST_IDLE : ST_REQ;
                end
`endif
            end
            ST_EVAL: begin
                eval_upd = 1'b1;
                ch_d     = ch_q + 2'd1;
                state_d  = (ch_q == CH_TEMP) ? ST_IDLE : ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= CH_PRESSURE;
            per_q      <= PER_RELOAD;
            cap_data_q <= 8'd0;
            cap_sel_q  <= CH_PRESSURE;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            per_q      <= per_d;
            cap_data_q <= cap_data_d;
            cap_sel_q  <= cap_sel_d;
        end
    end

`ifdef HCS_SCHED_TIMEOUT_EN
    // Restarts from zero on every REQ entry, including the back-to-back entry after a skip.
    assign tmo_d = (state_q == ST_REQ && state_d == ST_REQ && !tmo_fire) ? tmo_q + TW'(1) : '0;

    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tmo_fire && (ch_q == ch_t'(i))) begin
                fault_d[i] = 1'b1;
            end else if (alarm_clr[i]) begin
                fault_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q   <= '0;
            fault_q <= '0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT > 1);
    assign fault      = 4'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dbc
        hcs_debounce_ctr #(
            .DEBOUNCE(DEBOUNCE)
        ) u_dbc (
            .clk  (clk),
            .rst  (rst),
            .upd  (eval_upd && (cap_sel_q == ch_t'(g))),
            .flag (det_flag),
            .clr  (alarm_clr[g]),
            .count(count_unused[g]),
            .hit  (hit[g])
        );
    end

    assign sens_req = (state_q == ST_REQ);
    assign sens_sel = ch_q;
    assign cap_data = cap_data_q;
    assign cap_sel  = cap_sel_q;
    assign alarm    = hit;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hcs_sensor_scheduler.sv
// Directed-plus-random bench for hcs_sensor_scheduler against a per-channel arithmetic model.
module tb_hcs_sensor_scheduler;

    localparam int SP  = 4;
    localparam int DEB = 3;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sens_req;
    logic [1:0] sens_sel;
    logic       sens_ack;
    logic [7:0] sens_data;
    logic [7:0] cap_data;
    logic [1:0] cap_sel;
    logic       det_flag;
    logic [3:0] alarm;
    logic [3:0] alarm_clr;
    logic [3:0] fault;
    logic       busy;

    logic [3:0] det_vec;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cnt[4];
    logic [3:0] exp_alarm;
    logic [3:0] exp_fault;

    always #5 clk = ~clk;

    // Detector model: combinational abnormality flag per captured channel.
    assign det_flag = det_vec[cap_sel];

    hcs_sensor_scheduler #(
        .SAMPLE_PERIOD(SP),
        .DEBOUNCE     (DEB),
        .TIMEOUT      (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sens_req (sens_req),
        .sens_sel (sens_sel),
        .sens_ack (sens_ack),
        .sens_data(sens_data),
        .cap_data (cap_data),
        .cap_sel  (cap_sel),
        .det_flag (det_flag),
        .alarm    (alarm),
        .alarm_clr(alarm_clr),
        .fault    (fault),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        exp_alarm = 4'b0;
        exp_fault = 4'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   sens_req, 0);
        check({tag, "_sel"},   sens_sel, 0);
        check({tag, "_cdata"}, cap_data, 0);
        check({tag, "_csel"},  cap_sel, 0);
        check({tag, "_alarm"}, alarm, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    // Called just after reset release with enable high: REQ must appear after exactly SP edges.
    task automatic check_first_req();
        for (int k = 1; k < SP; k++) begin
            step();
            check("pre_req_low", sens_req, 0);
        end
        step();
        check("first_req", sens_req, 1);
        check("first_sel", sens_sel, 0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!sens_req && n < 2 * SP + 20) begin
            step();
            n++;
        end
        check(tag, sens_req, 1);
    endtask

    task automatic pulse_clr(input logic [3:0] mask);
        alarm_clr = mask;
        step();
        alarm_clr = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) cnt[i] = 0;
        end
        exp_alarm &= ~mask;
        exp_fault &= ~mask;
        check("clr_alarm", alarm, exp_alarm);
        check("clr_fault", fault, exp_fault);
    endtask

    // Channel never acked: returns whether the caller must still ack it.
    task automatic no_ack_phase(input int c, output bit need_ack);
`ifdef HCS_SCHED_TIMEOUT_EN
        for (int k = 1; k < TMO; k++) begin
            step();
            check("tmo_req_hold", sens_req, 1);
        end
        step();
        exp_fault[c] = 1'b1;
        check("tmo_req_drop", sens_req, (c == 3) ? 0 : 1);
        check("tmo_fault", fault, exp_fault);
        check("tmo_alarm", alarm, exp_alarm);
        need_ack = 1'b0;
`else
        repeat (TMO + 4) step();
        check("noto_req_hold", sens_req, 1);
        check("noto_fault", fault, 0);
        need_ack = 1'b1;
`endif
    endtask

    task automatic run_round(input logic [3:0] flags, input bit rnd, input int clr_ch,
                             input int stop_ch, input int noack_ch);
        int         dly;
        logic [7:0] d;
        bit         set;
        bit         need_ack;
        det_vec = flags;
        for (int c = 0; c < 4; c++) begin
            wait_req("req_wait");
            check("sens_sel", sens_sel, c);
            check("busy_req", busy, 1);
            if (c == stop_ch) enable = 1'b0;
            need_ack = 1'b1;
            if (c == noack_ch) no_ack_phase(c, need_ack);
            if (need_ack) begin
                dly = rnd ? int'($urandom_range(3, 0)) : 0;
                repeat (dly) begin
                    step();
                    check("req_hold", sens_req, 1);
                end
                d = (!rnd && c == 0) ? 8'hA5 : 8'($urandom);
                sens_ack  = 1'b1;
                sens_data = d;
                step();
                check("cap_data", cap_data, d);
                check("cap_sel", cap_sel, c);
                check("req_drop", sens_req, 0);
                // Ack seen outside REQ must not disturb the capture.
                sens_data = ~d;
                if (c == clr_ch) alarm_clr[c] = 1'b1;
                set = 1'b0;
                if (flags[c]) begin
                    if (cnt[c] < DEB) cnt[c]++;
                    if (cnt[c] == DEB) begin
                        exp_alarm[c] = 1'b1;
                        set = 1'b1;
                    end
                end else begin
                    cnt[c] = 0;
                end
                if (c == clr_ch && !set) begin
                    exp_alarm[c] = 1'b0;
                    cnt[c] = 0;
                end
                step();
                sens_ack  = 1'b0;
                alarm_clr = 4'b0;
                check("alarm", alarm, exp_alarm);
                check("cap_hold", cap_data, d);
            end
        end
        check("busy_end", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        rst       = 1'b1;
        enable    = 1'b0;
        sens_ack  = 1'b0;
        sens_data = 8'h00;
        alarm_clr = 4'b0;
        det_vec   = 4'b0;
        model_reset();
        #2;
        check_reset_outputs("rst0");
        step();
        step();
        rst    = 1'b0;
        enable = 1'b1;
        check_first_req();

        run_round(4'b0000, 1'b1, -1, -1, -1);

        // Reset while requesting: sens_req must drop without waiting for a clock edge.
        wait_req("req_before_rst");
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        step();
        rst = 1'b0;
        check_first_req();

        run_round(4'b0100, 1'b0, -1, -1, -1);
        run_round(4'b0100, 1'b1, -1, -1, -1);
        check("alarm2_not_yet", alarm, 4'b0000);
        run_round(4'b0100, 1'b1, -1, -1, -1);
        check("alarm2_raised", alarm, 4'b0100);

        pat = 4'b1011;
        for (int r = 0; r < 4; r++) begin
            run_round({1'($urandom), 1'($urandom), 1'b1, pat[3-r]}, 1'b1, -1, -1, -1);
        end
        check("alarm0_broken_run", alarm[0], 0);
        check("alarm1_raised", alarm[1], 1);

        pulse_clr(4'b0010);
        run_round(4'b0010, 1'b1, -1, -1, -1);
        run_round(4'b0010, 1'b1, -1, -1, -1);
        check("alarm1_restart", alarm[1], 0);
        run_round(4'b0010, 1'b1, 1, -1, -1);
        check("alarm1_set_wins", alarm[1], 1);

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(1, 0) == 1) pulse_clr(4'($urandom));
            run_round(4'($urandom), 1'b1, -1, -1, -1);
        end

        // Drop enable while channel 1 requests: round completes, then the scheduler stays idle.
        run_round(4'b0000, 1'b1, -1, 1, -1);
        for (int k = 0; k < 2 * SP + 4; k++) begin
            step();
            check("stopped_no_req", sens_req, 0);
        end
        check("stopped_busy", busy, 0);

        enable = 1'b1;
        run_round(4'b0000, 1'b0, -1, -1, 3);
        pulse_clr(4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
